wbr_ctrl: RTL

IEEE 1500 wrapper serial controller for the wrapper boundary register (WBR) built from WC_SD1_CII_O cells. It holds the 3-bit wrapper instruction register (WIR) and the 1-bit bypass register (WBY), and decodes the active instruction into the `wse_*`/`hold_*` controls for the input-cell and output-cell chains. It also steers WSO and counts WBR shift cycles to detect chain-length errors. It sits between the core-level wrapper serial port and the WBR chain.

---
 rtl/wbr_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/wbr_ctrl.sv
// IEEE 1500 wrapper serial controller: WIR, WBY, WBR cell controls and WSO steering.
// Define WBR_SHIFT_CHECK_EN to build the WBR shift-length counter and shift_err flag.
module wbr_ctrl #(
  parameter int WBR_LEN = 8,
  parameter int CNT_W   = 16
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       WSI,
  input  logic       SelectWIR,
  input  logic       CaptureWR,
  input  logic       ShiftWR,
  input  logic       UpdateWR,
  input  logic       wbr_so,
  output logic       WSO,
  output logic       wbr_si,
  output logic       wse_inputs,
  output logic       hold_inputs,
  output logic       wse_outputs,
  output logic       hold_outputs,
  output logic [2:0] instr,
  output logic       shift_err
);

  localparam logic [2:0] WS_BYPASS  = 3'b000;
  localparam logic [2:0] WS_EXTEST  = 3'b001;
  localparam logic [2:0] WS_INTEST  = 3'b010;
  localparam logic [2:0] WS_PRELOAD = 3'b011;

  if (WBR_LEN >= 2**CNT_W) begin : g_bad_cnt_w
    $error("wbr_ctrl: CNT_W too small for WBR_LEN");
  end

  logic [2:0] r_instr;
  logic [2:0] r_wir_sr;
  logic       r_wby;
  logic       w_cap;
  logic       w_shf;
  logic       w_upd;
  logic       w_wbr_sel;
  logic       w_wbr_act;
  logic       w_cap_cfi;
  logic       w_wse;
  logic       w_hold;

  // Strobe priority: capture > shift > update
  assign w_cap = CaptureWR;
  assign w_shf = ShiftWR & ~CaptureWR;
  assign w_upd = UpdateWR & ~CaptureWR & ~ShiftWR;

  assign w_wbr_sel = (r_instr == WS_EXTEST) || (r_instr == WS_INTEST) ||
                     (r_instr == WS_PRELOAD);
  assign w_wbr_act = w_wbr_sel & ~SelectWIR & ~reset;
  assign w_cap_cfi = (r_instr == WS_EXTEST) || (r_instr == WS_INTEST);

  // Cells act on the same edge as the strobe, so these stay combinational
  assign w_wse  = w_wbr_act & w_shf;
  assign w_hold = ~(w_wbr_act & (w_shf | (w_cap & w_cap_cfi)));

  assign wse_inputs   = w_wse;
  assign hold_inputs  = w_hold;
  assign wse_outputs  = w_wse;
  assign hold_outputs = w_hold;
  assign wbr_si       = WSI;
  assign instr        = r_instr;

  assign WSO = SelectWIR ? r_wir_sr[0] : (w_wbr_sel ? wbr_so : r_wby);

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_instr  <= WS_BYPASS;
      r_wir_sr <= 3'b000;
      r_wby    <= 1'b0;
    end else if (SelectWIR) begin
      if (w_cap)      r_wir_sr <= r_instr;
      else if (w_shf) r_wir_sr <= {WSI, r_wir_sr[2:1]};
      else if (w_upd) r_instr  <= r_wir_sr;
    end else if (!w_wbr_sel) begin
      if (w_cap)      r_wby <= 1'b0;
      else if (w_shf) r_wby <= WSI;
    end
  end

`ifdef WBR_SHIFT_CHECK_EN
  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(WBR_LEN);

  logic [CNT_W-1:0] r_cnt;
  logic             r_shift_err;

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_cnt       <= '0;
      r_shift_err <= 1'b0;
    end else if (w_wbr_sel && !SelectWIR) begin
      if (w_cap) begin
        r_cnt       <= '0;
        r_shift_err <= 1'b0;
      end else if (w_shf) begin
        if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
      end else if (w_upd) begin
        r_shift_err <= (r_cnt != LEN_C);
      end
    end
  end

  assign shift_err = r_shift_err;
`else
  assign shift_err = 1'b0;
`endif

endmodule
